// File: rtl/mem_copy_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : mem_copy_master                                               |
// | Description: Bus master that copies LEN words from SRC to DST, one read     |
// |              then one write per word (3 cycles/word).                      |
// |              Optional abort input enabled by macro MEM_COPY_ABORT_EN.      |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mem_copy_master #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_left,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
`ifdef MEM_COPY_ABORT_EN
  ,
  input  logic              abort
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0]  c_len_one  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_words;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd;
  logic                r_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_busy;
  logic                r_done;

  state_t              w_nxt_state;
  logic [ADDR_W-1:0]   w_nxt_src;
  logic [ADDR_W-1:0]   w_nxt_dst;
  logic [LEN_W-1:0]    w_nxt_words;
  logic [ADDR_W-1:0]   w_nxt_addr;
  logic                w_nxt_rd;
  logic                w_nxt_wr;
  logic [DATA_W-1:0]   w_nxt_wdata;
  logic                w_nxt_busy;
  logic                w_nxt_done;
  logic                w_abort;

`ifdef MEM_COPY_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_words <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_src   <= w_nxt_src;
      r_dst   <= w_nxt_dst;
      r_words <= w_nxt_words;
      r_addr  <= w_nxt_addr;
      r_rd    <= w_nxt_rd;
      r_wr    <= w_nxt_wr;
      r_wdata <= w_nxt_wdata;
      r_busy  <= w_nxt_busy;
      r_done  <= w_nxt_done;
    end
  end

  // Next-state logic also computes the next value of every output register,
  // so each output reflects the state being entered on the same edge.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_src   = r_src;
    w_nxt_dst   = r_dst;
    w_nxt_words = r_words;
    w_nxt_addr  = r_addr;
    w_nxt_rd    = 1'b0;
    w_nxt_wr    = 1'b0;
    w_nxt_wdata = r_wdata;
    w_nxt_busy  = r_busy;
    w_nxt_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nxt_words = len;
          if (len != '0) begin
            w_nxt_state = S_RD;
            w_nxt_src   = src_addr;
            w_nxt_dst   = dst_addr;
            w_nxt_addr  = src_addr;
            w_nxt_rd    = 1'b1;
            w_nxt_busy  = 1'b1;
          end else begin
            w_nxt_state = S_DONE;
            w_nxt_done  = 1'b1;
            w_nxt_busy  = 1'b0;
          end
        end
      end
      S_RD: begin
        if (w_abort) begin
          w_nxt_state = S_DONE;
          w_nxt_done  = 1'b1;
          w_nxt_busy  = 1'b0;
        end else begin
          w_nxt_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // Responder data is valid during WAIT; capture it for the write.
        if (w_abort) begin
          w_nxt_state = S_DONE;
          w_nxt_done  = 1'b1;
          w_nxt_busy  = 1'b0;
        end else begin
          w_nxt_state = S_WR;
          w_nxt_addr  = r_dst;
          w_nxt_wr    = 1'b1;
          w_nxt_wdata = mem_rd_data;
        end
      end
      S_WR: begin
        w_nxt_words = r_words - c_len_one;
        w_nxt_src   = r_src + c_addr_one;
        w_nxt_dst   = r_dst + c_addr_one;
        if ((r_words == c_len_one) || w_abort) begin
          w_nxt_state = S_DONE;
          w_nxt_done  = 1'b1;
          w_nxt_busy  = 1'b0;
        end else begin
          w_nxt_state = S_RD;
          w_nxt_addr  = r_src + c_addr_one;
          w_nxt_rd    = 1'b1;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
        w_nxt_busy  = 1'b0;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign words_left  = r_words;
  assign mem_addr    = r_addr;
  assign mem_rd_en   = r_rd;
  assign mem_wr_en   = r_wr;
  assign mem_wr_data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_mem_copy_master                                            |
// | Description: Randomized self-checking bench with a word-copy memory model.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic [15:0] mem_rd_data = '0;
  logic        busy, done, mem_rd_en, mem_wr_en;
  logic [15:0] words_left, mem_addr, mem_wr_data;
`ifdef MEM_COPY_ABORT_EN
  logic        abort = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_copy_master #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .words_left(words_left),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
`ifdef MEM_COPY_ABORT_EN
    , .abort(abort)
`endif
  );

  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] pend = '0;
  int checks = 0;
  int errors = 0;

  int          o_done, o_nrd, o_nwr, o_both, o_busy_bad;
  int          o_rd_cyc[$];
  logic [15:0] o_rd_addr[$];
  logic [15:0] o_wr_addr[$];
  logic [15:0] o_wr_data[$];
  logic [15:0] o_wl_done;
  logic [51:0] o_rst_outs;
  logic [15:0] exp_data[$];

  // One clock: responder drives read data registered one cycle after the strobe.
  task automatic step();
    @(posedge clk);
    #1 mem_rd_data = pend;
    @(negedge clk);
  endtask

  // Reference: ascending word copy with no overlap correction, modulo 2^16.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    logic [15:0] sa, da;
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      exp_data.push_back(ref_mem[sa]);
      ref_mem[da] = ref_mem[sa];
    end
  endtask

  // Drives one transfer and records the bus activity, emulating the RAM.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                          input int abort_cyc, input int rst_cyc, input bit poke);
    o_done = -1; o_nrd = 0; o_nwr = 0; o_both = 0; o_busy_bad = 0;
    o_rd_cyc.delete(); o_rd_addr.delete(); o_wr_addr.delete(); o_wr_data.delete();
    src_addr = s; dst_addr = d; len = n; start = 1'b1; pend = '0;
    step();
    start = 1'b0;
    src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 16'($urandom);
    for (int c = 1; c <= 3 * int'(n) + 20; c++) begin
      if (c == rst_cyc) begin
        reset = 1'b1;
        #1 o_rst_outs = {busy, done, words_left, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data};
        pend = '0; mem_rd_data = '0;
        return;
      end
      if (mem_rd_en && mem_wr_en) o_both++;
      if (mem_rd_en) begin
        o_nrd++; o_rd_cyc.push_back(c); o_rd_addr.push_back(mem_addr);
      end
      if (mem_wr_en) begin
        o_nwr++; o_wr_addr.push_back(mem_addr); o_wr_data.push_back(mem_wr_data);
        mem[mem_addr] = mem_wr_data;
      end
      pend = mem_rd_en ? mem[mem_addr] : 16'h0;
      if (done) begin
        o_done = c; o_wl_done = words_left;
        if (busy !== 1'b0) o_busy_bad++;
        break;
      end
      if (busy !== 1'b1) o_busy_bad++;
      start = poke && (c == 5);
`ifdef MEM_COPY_ABORT_EN
      abort = (c == abort_cyc);
`endif
      step();
    end
`ifdef MEM_COPY_ABORT_EN
    abort = 1'b0;
`endif
    start = poke;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    checks++;
    if ({busy, done, words_left, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data} !== 52'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0",
        {busy, done, words_left, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data});
    end
    reset = 1'b0;
    step();
    checks++;
    if ({busy, done, mem_rd_en, mem_wr_en} !== 4'b0) begin
      errors++; $display("FAIL reset_idle got %b want 0000", {busy, done, mem_rd_en, mem_wr_en});
    end
  endtask

  task automatic test_basic();
    logic [15:0] want[3] = '{16'hA1, 16'hB2, 16'hC3};
    for (int i = 0; i < 3; i++) begin
      mem[16'h0100 + 16'(i)] = want[i]; ref_mem[16'h0100 + 16'(i)] = want[i];
    end
    model_copy(16'h0100, 16'h0200, 3);
    run_copy(16'h0100, 16'h0200, 16'd3, -1, -1, 1'b0);
    checks++;
    if (o_done !== 10) begin errors++; $display("FAIL basic_done_cycle got %0d want 10", o_done); end
    checks++;
    if (o_rd_cyc.size() !== 3) begin
      errors++; $display("FAIL basic_rd_count got %0d want 3", o_rd_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o_rd_cyc[i] !== 1 + 3 * i) begin
          errors++; $display("FAIL basic_rd_cycle[%0d] got %0d want %0d", i, o_rd_cyc[i], 1 + 3 * i);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[16'h0200 + 16'(i)] !== want[i]) begin
        errors++; $display("FAIL basic_dst[%0d] got %h want %h", i, mem[16'h0200 + 16'(i)], want[i]);
      end
    end
    checks++;
    if ({o_busy_bad, o_both, 16'(o_wl_done)} !== 80'h0) begin
      errors++; $display("FAIL basic_protocol busy_bad %0d both %0d words_left %0d want 0 0 0",
        o_busy_bad, o_both, o_wl_done);
    end
  endtask

  task automatic test_len0();
    run_copy(16'h1234, 16'h5678, 16'd0, -1, -1, 1'b0);
    checks++;
    if (o_done !== 1) begin errors++; $display("FAIL len0_done_cycle got %0d want 1", o_done); end
    checks++;
    if (o_nrd + o_nwr + o_busy_bad !== 0) begin
      errors++; $display("FAIL len0_strobes rd %0d wr %0d busy_bad %0d want 0", o_nrd, o_nwr, o_busy_bad);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy_after got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    model_copy(16'hFFFF, 16'h4000, 2);
    run_copy(16'hFFFF, 16'h4000, 16'd2, -1, -1, 1'b0);
    checks++;
    if (o_rd_addr.size() !== 2) begin
      errors++; $display("FAIL wrap_rd_count got %0d want 2", o_rd_addr.size());
    end else begin
      checks++;
      if (o_rd_addr[1] !== 16'h0000) begin
        errors++; $display("FAIL wrap_second_addr got %h want 0000", o_rd_addr[1]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem[16'h4000 + 16'(i)] !== exp_data[i]) begin
        errors++; $display("FAIL wrap_dst[%0d] got %h want %h", i, mem[16'h4000 + 16'(i)], exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] s, d, a;
    int n;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(1, 6);
      s = 16'($urandom);
      d = (it % 3 == 0) ? s + 16'($urandom_range(1, 3)) : 16'($urandom);
      model_copy(s, d, n);
      run_copy(s, d, 16'(n), -1, -1, 1'b0);
      checks++;
      if (o_done !== 3 * n + 1) begin
        errors++; $display("FAIL rand%0d_done got %0d want %0d", it, o_done, 3 * n + 1);
      end
      checks++;
      if (o_nwr !== n || o_nrd !== n || o_both !== 0) begin
        errors++; $display("FAIL rand%0d_counts rd %0d wr %0d both %0d want %0d %0d 0",
          it, o_nrd, o_nwr, o_both, n, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (o_rd_addr[i] !== s + 16'(i) || o_wr_addr[i] !== d + 16'(i) || o_wr_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL rand%0d_beat%0d got rd %h wr %h data %h want %h %h %h", it, i,
              o_rd_addr[i], o_wr_addr[i], o_wr_data[i], s + 16'(i), d + 16'(i), exp_data[i]);
          end
        end
      end
      for (int i = -1; i <= n; i++) begin
        a = d + 16'(i);
        checks++;
        if (mem[a] !== ref_mem[a]) begin
          errors++; $display("FAIL rand%0d_mem[%h] got %h want %h", it, a, mem[a], ref_mem[a]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int bad = 0;
    model_copy(16'h3000, 16'h3800, 4);
    run_copy(16'h3000, 16'h3800, 16'd4, -1, -1, 1'b1);
    checks++;
    if (o_done !== 13) begin errors++; $display("FAIL restart_done got %0d want 13", o_done); end
    checks++;
    if (o_nwr !== 4) begin
      errors++; $display("FAIL restart_writes got %0d want 4", o_nwr);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (o_wr_addr[i] !== 16'h3800 + 16'(i) || o_wr_data[i] !== exp_data[i]) begin
          errors++; $display("FAIL restart_beat%0d got %h/%h want %h/%h", i,
            o_wr_addr[i], o_wr_data[i], 16'h3800 + 16'(i), exp_data[i]);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      if (busy || done || mem_rd_en || mem_wr_en) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL restart_in_done got %0d active cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    model_copy(16'h5000, 16'h5800, 1);
    run_copy(16'h5000, 16'h5800, 16'd4, -1, 6, 1'b0);
    checks++;
    if (o_rst_outs !== 52'h0) begin
      errors++; $display("FAIL rstmid_outputs got %h want 0", o_rst_outs);
    end
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done || busy || mem_rd_en || mem_wr_en) dones++;
      step();
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", dones); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem[16'h5800 + 16'(i)] !== ref_mem[16'h5800 + 16'(i)]) begin
        errors++; $display("FAIL rstmid_dst[%0d] got %h want %h", i,
          mem[16'h5800 + 16'(i)], ref_mem[16'h5800 + 16'(i)]);
      end
    end
    model_copy(16'h6000, 16'h6800, 2);
    run_copy(16'h6000, 16'h6800, 16'd2, -1, -1, 1'b0);
    checks++;
    if (o_done !== 7 || mem[16'h6801] !== exp_data[1]) begin
      errors++; $display("FAIL rstmid_restart got done %0d data %h want 7 %h", o_done, mem[16'h6801], exp_data[1]);
    end
  endtask

`ifdef MEM_COPY_ABORT_EN
  task automatic test_abort();
    int acyc[2] = '{5, 9};
    int nw, ph;
    for (int k = 0; k < 2; k++) begin
      ph = (acyc[k] - 1) % 3;
      nw = (acyc[k] - 1) / 3 + ((ph == 2) ? 1 : 0);
      model_copy(16'h7000 + 16'(k * 16), 16'h7800 + 16'(k * 16), nw);
      run_copy(16'h7000 + 16'(k * 16), 16'h7800 + 16'(k * 16), 16'd4, acyc[k], -1, 1'b0);
      checks++;
      if (o_nwr !== nw || o_done !== acyc[k] + 1 || o_wl_done !== 16'(4 - nw)) begin
        errors++; $display("FAIL abort%0d got writes %0d done %0d left %0d want %0d %0d %0d",
          k, o_nwr, o_done, o_wl_done, nw, acyc[k] + 1, 4 - nw);
      end
      checks++;
      if (mem[16'h7800 + 16'(k * 16 + nw)] !== ref_mem[16'h7800 + 16'(k * 16 + nw)]) begin
        errors++; $display("FAIL abort%0d_untouched got %h want %h", k,
          mem[16'h7800 + 16'(k * 16 + nw)], ref_mem[16'h7800 + 16'(k * 16 + nw)]);
      end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_random();
    test_start_ignored();
    test_reset_mid();
`ifdef MEM_COPY_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
